// File: rtl/conv_pre_ctrl.sv
// Layer sequencer for the conv pre-processing stage: takes one descriptor, gates pixel beats, emits window-valid.
// Latency: descriptor accept -> buff_len_rst next cycle -> src_ready the cycle after; PW window PW_LAT cycles after beat.
// Backpressure: cfg_ready only in IDLE; src_ready only in STREAM and drops right after the last beat of the layer.
// Ports: cfg_* descriptor handshake; src_valid/src_ready/pre_valid_in pixel gating; buff_len_ctrl/buff_len_rst/pw_mode
//        drive the row buffers and window mux; pre_valid_out/win_valid window path; busy/layer_done/cfg_err status.
module conv_pre_ctrl #(
    parameter int ROW_BUFFER_DEPTH = 9,
    parameter int PW_LAT           = 3,
    parameter int CNT_WIDTH        = 18,
    parameter int DRAIN_TIMEOUT    = 1023
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic                        cfg_pw_mode,
    input  logic [ROW_BUFFER_DEPTH-1:0] cfg_row_len,
    input  logic [ROW_BUFFER_DEPTH-1:0] cfg_row_num,
    input  logic                        src_valid,
    output logic                        src_ready,
    output logic                        pre_valid_in,
    output logic [ROW_BUFFER_DEPTH-1:0] buff_len_ctrl,
    output logic                        buff_len_rst,
    output logic                        pw_mode,
    input  logic                        pre_valid_out,
    output logic                        win_valid,
    output logic                        busy,
    output logic                        layer_done,
    output logic                        cfg_err
);

    localparam int IW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [ROW_BUFFER_DEPTH-1:0] row_len_q;
    logic [ROW_BUFFER_DEPTH-1:0] row_num_q;
    logic [ROW_BUFFER_DEPTH-1:0] col;
    logic [ROW_BUFFER_DEPTH-1:0] row;
    logic [CNT_WIDTH-1:0]        exp_cnt;
    logic [CNT_WIDTH-1:0]        win_cnt;
    logic [CNT_WIDTH-1:0]        win_cnt_inc;
    logic [IW-1:0]               idle_cnt;
    logic [IW-1:0]               idle_cnt_inc;
    logic [PW_LAT-1:0]           pw_pipe;
    logic                        cfg_legal;
    logic                        beat;
    logic                        last_beat;
    logic                        win_counted;
    logic                        win_hit;
    logic                        drain_timeout;

    // DW needs a full 3x3 neighbourhood, so both dimensions must be at least 3.
    assign cfg_legal = (cfg_row_len != '0) && (cfg_row_num != '0) &&
                       (cfg_pw_mode || ((cfg_row_len >= ROW_BUFFER_DEPTH'(3)) &&
                                        (cfg_row_num >= ROW_BUFFER_DEPTH'(3))));

    // Decoded from state directly (not src_ready) to keep the comb path loop-free.
    assign beat         = src_valid && (state == S_STREAM);
    assign pre_valid_in = beat;
    assign last_beat    = beat && (row == row_num_q - ROW_BUFFER_DEPTH'(1)) &&
                          (col == row_len_q - ROW_BUFFER_DEPTH'(1));

    // PW windows come out of a fixed-latency path; DW windows are flagged by the stage itself.
    assign win_valid    = pw_mode ? pw_pipe[PW_LAT-1] : pre_valid_out;
    assign win_counted  = win_valid && ((state == S_STREAM) || (state == S_DRAIN));
    assign win_cnt_inc  = win_cnt + CNT_WIDTH'(win_counted);
    // Includes the current window so DONE follows the final window with no extra cycle.
    assign win_hit      = (win_cnt_inc >= exp_cnt);
    assign idle_cnt_inc = win_valid ? '0 : idle_cnt + IW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cfg_ready     = 1'b0;
        src_ready     = 1'b0;
        buff_len_rst  = 1'b0;
        busy          = 1'b1;
        layer_done    = 1'b0;
        drain_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid && cfg_legal) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                buff_len_rst = 1'b1;
                state_nxt    = S_STREAM;
            end
            S_STREAM: begin
                src_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (win_hit) begin
                    state_nxt = S_DONE;
                end else if (idle_cnt_inc == IDLE_MAX) begin
                    drain_timeout = 1'b1;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                layer_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_len_q     <= '0;
            row_num_q     <= '0;
            pw_mode       <= 1'b0;
            buff_len_ctrl <= '0;
            cfg_err       <= 1'b0;
            pw_pipe       <= '0;
            col           <= '0;
            row           <= '0;
            exp_cnt       <= '0;
            win_cnt       <= '0;
            idle_cnt      <= '0;
        end else begin
            cfg_err <= drain_timeout;
            pw_pipe <= (pw_pipe << 1) | PW_LAT'(beat);
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_legal) begin
                            row_len_q     <= cfg_row_len;
                            row_num_q     <= cfg_row_num;
                            pw_mode       <= cfg_pw_mode;
                            buff_len_ctrl <= cfg_row_len - ROW_BUFFER_DEPTH'(2);
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // pw_mode already reflects the accepted descriptor here.
                    if (pw_mode) begin
                        exp_cnt <= CNT_WIDTH'(row_len_q) * CNT_WIDTH'(row_num_q);
                    end else begin
                        exp_cnt <= CNT_WIDTH'(row_len_q - ROW_BUFFER_DEPTH'(2)) *
                                   CNT_WIDTH'(row_num_q - ROW_BUFFER_DEPTH'(2));
                    end
                    col      <= '0;
                    row      <= '0;
                    win_cnt  <= '0;
                    idle_cnt <= '0;
                end
                S_STREAM: begin
                    win_cnt <= win_cnt_inc;
                    if (beat) begin
                        if (col == row_len_q - ROW_BUFFER_DEPTH'(1)) begin
                            col <= '0;
                            row <= row + ROW_BUFFER_DEPTH'(1);
                        end else begin
                            col <= col + ROW_BUFFER_DEPTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    win_cnt  <= win_cnt_inc;
                    idle_cnt <= idle_cnt_inc;
                end
                S_DONE: begin
                    col      <= '0;
                    row      <= '0;
                    exp_cnt  <= '0;
                    win_cnt  <= '0;
                    idle_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pre_ctrl.sv
// Self-checking bench for conv_pre_ctrl: cycle-timeline reference model plus directed and random layers.
// Every output is compared every cycle; per-layer totals are compared against counts derived from the descriptor.
module tb_conv_pre_ctrl;

    localparam int RBD = 9;
    localparam int TMO = 1023;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           cfg_pw_mode;
    logic [RBD-1:0] cfg_row_len;
    logic [RBD-1:0] cfg_row_num;
    logic           src_valid;
    logic           src_ready;
    logic           pre_valid_in;
    logic [RBD-1:0] buff_len_ctrl;
    logic           buff_len_rst;
    logic           pw_mode;
    logic           pre_valid_out;
    logic           win_valid;
    logic           busy;
    logic           layer_done;
    logic           cfg_err;

    conv_pre_ctrl #(
        .ROW_BUFFER_DEPTH(RBD),
        .PW_LAT(LAT),
        .CNT_WIDTH(18),
        .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_pw_mode(cfg_pw_mode),
        .cfg_row_len(cfg_row_len),
        .cfg_row_num(cfg_row_num),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .pre_valid_in(pre_valid_in),
        .buff_len_ctrl(buff_len_ctrl),
        .buff_len_rst(buff_len_rst),
        .pw_mode(pw_mode),
        .pre_valid_out(pre_valid_out),
        .win_valid(win_valid),
        .busy(busy),
        .layer_done(layer_done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             pw;
        logic [RBD-1:0] rl;
        logic [RBD-1:0] rn;
    } desc_t;

    desc_t desc_q[$];
    int    pw_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;

    // Reference timeline of the current layer
    bit             m_active;
    bit             m_pw;
    bit             m_pw_out;
    logic [RBD-1:0] m_len_out;
    int m_tacc, m_total, m_got, m_wexp, m_wgot, m_tlast, m_done_t, m_err_t, m_idle_run;
    int m_r, m_c, m_rl, m_emitted;

    // Stimulus knobs and upstream-stage model
    bit dw_pend;
    int stall_after = -1;
    int src_mode = 0;
    int src_pct = 100;

    // Observed DUT activity for per-layer totals
    int obs_pvi, obs_win, obs_done, obs_err, obs_rst, obs_len;
    int obs_rst_cyc, obs_err_cyc, obs_last_pvi, obs_first_done_cyc, obs_pw_at_first_done;
    bit obs_busy_any;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit legal(input desc_t d);
        return (d.rl >= 1) && (d.rn >= 1) && (d.pw || ((d.rl >= 3) && (d.rn >= 3)));
    endfunction

    task automatic clear_obs();
        obs_pvi = 0; obs_win = 0; obs_done = 0; obs_err = 0; obs_rst = 0; obs_len = -1;
        obs_rst_cyc = -1; obs_err_cyc = -1; obs_last_pvi = -1; obs_first_done_cyc = -1;
        obs_pw_at_first_done = -1; obs_busy_any = 1'b0;
    endtask

    task automatic step();
        desc_t d;
        bit    idle_now, ex_stream, ex_src_ready, ex_pvi, hit, ex_win, ex_count;
        bit    ex_done, ex_err, ex_rst;
        @(posedge clk);
        #1;
        cyc++;
        case (src_mode)
            0:       src_valid = 1'b1;
            1:       src_valid = ~src_valid;
            default: src_valid = ($urandom_range(99) < src_pct);
        endcase
        if (desc_q.size() > 0) begin
            d           = desc_q[0];
            cfg_valid   = 1'b1;
            cfg_pw_mode = d.pw;
            cfg_row_len = d.rl;
            cfg_row_num = d.rn;
        end else begin
            cfg_valid   = 1'b0;
            cfg_pw_mode = 1'($urandom_range(1));
            cfg_row_len = RBD'($urandom_range(511));
            cfg_row_num = RBD'($urandom_range(511));
        end
        // In PW mode the stage's DW flag must be ignored, so drive noise on it.
        pre_valid_out = m_pw_out ? 1'($urandom_range(1)) : dw_pend;
        dw_pend = 1'b0;
        #1;

        idle_now     = !m_active;
        ex_stream    = m_active && (cyc >= m_tacc + 2);
        ex_src_ready = ex_stream && (m_got < m_total);
        ex_pvi       = src_valid && ex_src_ready;
        hit          = (pw_q.size() > 0) && (pw_q[0] == cyc - LAT);
        if (hit) void'(pw_q.pop_front());
        ex_win       = m_pw_out ? hit : pre_valid_out;
        ex_count     = ex_stream && (m_done_t < 0);
        ex_done      = m_active && (cyc == m_done_t);
        ex_err       = (cyc == m_err_t);
        ex_rst       = m_active && (cyc == m_tacc + 1);

        chk("cfg_ready", 32'(cfg_ready), 32'(idle_now));
        chk("busy", 32'(busy), 32'(m_active));
        chk("src_ready", 32'(src_ready), 32'(ex_src_ready));
        chk("pre_valid_in", 32'(pre_valid_in), 32'(ex_pvi));
        chk("buff_len_rst", 32'(buff_len_rst), 32'(ex_rst));
        chk("buff_len_ctrl", 32'(buff_len_ctrl), 32'(m_len_out));
        chk("pw_mode", 32'(pw_mode), 32'(m_pw_out));
        chk("win_valid", 32'(win_valid), 32'(ex_win));
        chk("layer_done", 32'(layer_done), 32'(ex_done));
        chk("cfg_err", 32'(cfg_err), 32'(ex_err));

        if (pre_valid_in) begin obs_pvi++; obs_last_pvi = cyc; end
        if (win_valid && busy) obs_win++;
        if (layer_done) begin
            if (obs_done == 0) begin
                obs_first_done_cyc   = cyc;
                obs_pw_at_first_done = int'(pw_mode);
            end
            obs_done++;
        end
        if (cfg_err) begin obs_err++; obs_err_cyc = cyc; end
        if (buff_len_rst) begin obs_rst++; obs_len = int'(buff_len_ctrl); obs_rst_cyc = cyc; end
        if (busy) obs_busy_any = 1'b1;

        if (ex_count && ex_win) m_wgot++;
        if (m_active && (m_tlast >= 0) && (cyc > m_tlast) && (m_done_t < 0)) begin
            m_idle_run = ex_win ? 0 : m_idle_run + 1;
            if (m_wgot >= m_wexp) begin
                m_done_t = cyc + 1;
            end else if (m_idle_run >= TMO) begin
                m_done_t = cyc + 1;
                m_err_t  = cyc + 1;
            end
        end
        if (ex_pvi) begin
            pw_q.push_back(cyc);
            // The stage completes a 3x3 window once a pixel at row>=2, col>=2 arrives.
            if (!m_pw && (m_r >= 2) && (m_c >= 2) && ((stall_after < 0) || (m_emitted < stall_after))) begin
                dw_pend = 1'b1;
                m_emitted++;
            end
            m_c++;
            if (m_c == m_rl) begin m_c = 0; m_r++; end
            m_got++;
            if (m_got == m_total) m_tlast = cyc;
        end
        if (ex_done) m_active = 1'b0;
        if (idle_now && cfg_valid) begin
            if (legal(d)) begin
                m_active   = 1'b1;
                m_tacc     = cyc;
                m_pw       = d.pw;
                m_rl       = int'(d.rl);
                m_total    = int'(d.rl) * int'(d.rn);
                m_wexp     = d.pw ? m_total : (int'(d.rl) - 2) * (int'(d.rn) - 2);
                m_got      = 0; m_wgot = 0; m_tlast = -1; m_done_t = -1; m_idle_run = 0;
                m_r        = 0; m_c = 0; m_emitted = 0;
                m_pw_out   = d.pw;
                m_len_out  = d.rl - RBD'(2);
            end else begin
                m_err_t = cyc + 1;
            end
            void'(desc_q.pop_front());
        end
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while (((desc_q.size() > 0) || m_active) && (n < bound));
        chk("run_reached_idle", 32'((desc_q.size() > 0) || m_active), 32'(0));
        step();
    endtask

    task automatic check_reset_outputs();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_src_ready", 32'(src_ready), 32'(0));
        chk("rst_pre_valid_in", 32'(pre_valid_in), 32'(0));
        chk("rst_buff_len_rst", 32'(buff_len_rst), 32'(0));
        chk("rst_buff_len_ctrl", 32'(buff_len_ctrl), 32'(0));
        chk("rst_pw_mode", 32'(pw_mode), 32'(0));
        chk("rst_win_valid", 32'(win_valid), 32'(0));
        chk("rst_layer_done", 32'(layer_done), 32'(0));
        chk("rst_cfg_err", 32'(cfg_err), 32'(0));
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_pw_out = 1'b0; m_len_out = '0; m_err_t = -1; m_done_t = -1;
        pw_q.delete(); desc_q.delete(); dw_pend = 1'b0;
    endtask

    task automatic apply_reset();
        #1;
        pre_valid_out = 1'b0;
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic push(input bit pw, input int rl, input int rn);
        desc_t d;
        d.pw = pw;
        d.rl = RBD'(rl);
        d.rn = RBD'(rn);
        desc_q.push_back(d);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        desc_t rd;
        int    n;
        cfg_valid = 1'b0; cfg_pw_mode = 1'b0; cfg_row_len = '0; cfg_row_num = '0;
        src_valid = 1'b0; pre_valid_out = 1'b0;
        model_reset();
        clear_obs();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;

        // DW 5x4, continuous pixels
        clear_obs(); src_mode = 0;
        push(1'b0, 5, 4);
        run_until_idle(500);
        chk("dw_beats", 32'(obs_pvi), 32'(20));
        chk("dw_windows", 32'(obs_win), 32'(6));
        chk("dw_done_once", 32'(obs_done), 32'(1));
        chk("dw_rst_once", 32'(obs_rst), 32'(1));
        chk("dw_len_at_rst", 32'(obs_len), 32'(3));

        // PW 4x2, toggling pixels
        clear_obs(); src_mode = 1;
        push(1'b1, 4, 2);
        run_until_idle(500);
        chk("pw_beats", 32'(obs_pvi), 32'(8));
        chk("pw_windows", 32'(obs_win), 32'(8));
        chk("pw_done_once", 32'(obs_done), 32'(1));

        // Illegal DW descriptor
        clear_obs(); src_mode = 0;
        push(1'b0, 2, 5);
        run_until_idle(50);
        chk("ill_err", 32'(obs_err), 32'(1));
        chk("ill_busy", 32'(obs_busy_any), 32'(0));
        chk("ill_rst", 32'(obs_rst), 32'(0));

        // DW with the window source stalled after 2 of 6 windows
        clear_obs(); src_mode = 0; stall_after = 2;
        push(1'b0, 5, 4);
        run_until_idle(3000);
        stall_after = -1;
        chk("tmo_err", 32'(obs_err), 32'(1));
        chk("tmo_spacing", 32'(obs_err_cyc - obs_last_pvi), 32'(TMO + 1));
        chk("tmo_done", 32'(obs_done), 32'(1));
        chk("tmo_cfg_ready_back", 32'(cfg_ready), 32'(1));

        // Reset in STREAM after 7 beats, then a fresh PW layer
        clear_obs(); src_mode = 0;
        push(1'b1, 4, 4);
        n = 0;
        while ((obs_pvi < 7) && (n < 100)) begin step(); n++; end
        chk("abort_beats", 32'(obs_pvi), 32'(7));
        apply_reset();
        chk("abort_no_done", 32'(obs_done), 32'(0));
        clear_obs(); src_mode = 2; src_pct = 60;
        push(1'b1, 3, 3);
        run_until_idle(500);
        chk("post_rst_beats", 32'(obs_pvi), 32'(9));
        chk("post_rst_windows", 32'(obs_win), 32'(9));
        chk("post_rst_done", 32'(obs_done), 32'(1));

        // Back-to-back DW then PW with cfg_valid held
        clear_obs(); src_mode = 0;
        push(1'b0, 3, 3);
        push(1'b1, 2, 2);
        run_until_idle(500);
        chk("b2b_done", 32'(obs_done), 32'(2));
        chk("b2b_rst", 32'(obs_rst), 32'(2));
        chk("b2b_gap", 32'(obs_rst_cyc - obs_first_done_cyc), 32'(2));
        chk("b2b_mode_at_first_done", 32'(obs_pw_at_first_done), 32'(0));

        // Random descriptors and pixel rates
        for (int i = 0; i < 25; i++) begin
            clear_obs();
            src_mode = 2;
            src_pct  = $urandom_range(30, 100);
            rd.pw = 1'($urandom_range(1));
            rd.rl = RBD'($urandom_range(7));
            rd.rn = RBD'($urandom_range(6));
            desc_q.push_back(rd);
            run_until_idle(3000);
            if (legal(rd)) begin
                chk("rnd_beats", 32'(obs_pvi), 32'(int'(rd.rl) * int'(rd.rn)));
                chk("rnd_done", 32'(obs_done), 32'(1));
                chk("rnd_err", 32'(obs_err), 32'(0));
            end else begin
                chk("rnd_ill_err", 32'(obs_err), 32'(1));
                chk("rnd_ill_rst", 32'(obs_rst), 32'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
